// File: rtl/uart_mon_ctrl.sv
// uart_mon_ctrl: line-oriented monitor (w/r/g/q/p) over a byte stream driving a shared memory port.
// Define UART_MON_ECHO_EN to echo accepted rx bytes on tx.
module uart_mon_ctrl #(
  parameter int ADR_W = 10,
  parameter int NCH = 2,
  parameter int CHW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [CHW-1:0]   mem_ch,
  output logic [ADR_W-1:0] mem_adr,
  output logic [31:0]      mem_wdata,
  output logic             mem_wen,
  output logic             mem_ren,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      pc_data,
  output logic             cpu_start,
  output logic             quit_cmd,
  output logic [ADR_W-1:0] start_adr,
  output logic             err
);
  localparam logic [3:0] IDLE = 4'd0, CMD = 4'd1, TOKEN = 4'd2, EXEC = 4'd3, RD_REQ = 4'd4,
                         RD_WAIT = 4'd5, SEND_HEX = 4'd6, SEND_CRLF = 4'd7, ERR_FLUSH = 4'd8;
  logic [3:0] st, tcnt, hcnt;
  logic [7:0] cmd;
  logic [31:0] acc, dat;
  logic [CHW-1:0] ch;
  logic [ADR_W-1:0] adr_a, adr_e;
  logic has, bad, last, lf_pend, rx_go, is_cr, is_sp, is_lf, tok_end, wr, ch_bad, slot, known, ok;
  logic [4:0] nib;
  function automatic logic [7:0] hexc(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction
  always_comb begin
    rx_go = rx_valid && rx_ready;
    is_cr = rx_data == 8'h0d;
    is_sp = rx_data == 8'h20;
    is_lf = rx_data == 8'h0a;
    nib = (rx_data >= 8'h30 && rx_data <= 8'h39) ? {1'b1, rx_data[3:0]} :
          ((rx_data >= 8'h41 && rx_data <= 8'h46) || (rx_data >= 8'h61 && rx_data <= 8'h66)) ?
          {1'b1, rx_data[3:0] + 4'd9} : 5'd0;
    known = rx_data inside {8'h77, 8'h72, 8'h67, 8'h71, 8'h70};
    tok_end = rx_go && st == TOKEN && has && (is_sp || is_cr);
    wr = tok_end && cmd == 8'h77 && tcnt >= 4'd2 && !bad;
    ch_bad = tok_end && tcnt == 4'd0 && (cmd == 8'h77 || cmd == 8'h72) && 32'(acc[CHW-1:0]) >= 32'(NCH);
    slot = !tx_valid || tx_ready;
    ok = cmd == 8'h77 ? tcnt >= 4'd3 :
         cmd == 8'h72 ? (tcnt == 4'd3 && adr_e >= adr_a) :
         cmd == 8'h67 ? tcnt == 4'd1 : tcnt == 4'd0;
  end
  assign mem_ren = !rst && st == RD_REQ;
`ifdef UART_MON_ECHO_EN
  assign rx_ready = !rst && (st == IDLE || st == CMD || st == TOKEN) && !tx_valid && !lf_pend;
`else
  assign rx_ready = !rst && (st == IDLE || st == CMD || st == TOKEN);
  assign lf_pend = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      cmd <= '0;
      acc <= '0;
      dat <= '0;
      ch <= '0;
      adr_a <= '0;
      adr_e <= '0;
      tcnt <= '0;
      hcnt <= '0;
      has <= 1'b0;
      bad <= 1'b0;
      last <= 1'b0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      mem_ch <= '0;
      mem_adr <= '0;
      mem_wdata <= '0;
      mem_wen <= 1'b0;
      cpu_start <= 1'b0;
      quit_cmd <= 1'b0;
      start_adr <= '0;
      err <= 1'b0;
`ifdef UART_MON_ECHO_EN
      lf_pend <= 1'b0;
`endif
    end else begin
      mem_wen <= wr;
      err <= 1'b0;
      cpu_start <= 1'b0;
      quit_cmd <= 1'b0;
      // mem_adr trails adr_a by one edge, so a write captures the pre-increment address
      mem_adr <= adr_a;
      mem_ch <= ch;
      if (wr) begin
        mem_wdata <= acc;
        adr_a <= adr_a + 1'b1;
      end
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
`ifdef UART_MON_ECHO_EN
      if (rx_go) begin
        tx_data <= rx_data;
        tx_valid <= 1'b1;
        lf_pend <= is_cr;
      end else if (lf_pend && slot) begin
        tx_data <= 8'h0a;
        tx_valid <= 1'b1;
        lf_pend <= 1'b0;
      end
`endif
      case (st)
        IDLE: if (rx_go && !is_lf && !is_cr) begin
          cmd <= rx_data;
          bad <= !known;
          err <= !known;
          tcnt <= '0;
          acc <= '0;
          has <= 1'b0;
          st <= CMD;
        end
        CMD: if (rx_go) begin
          if (is_cr) begin
            dat <= pc_data;
            st <= EXEC;
          end else if (is_sp) st <= TOKEN;
          else if (!is_lf && !bad) begin
            bad <= 1'b1;
            err <= 1'b1;
          end
        end
        TOKEN: if (rx_go && !is_lf) begin
          if (is_sp || is_cr) begin
            if (has) begin
              tcnt <= tcnt + {3'b0, tcnt != 4'd15};
              acc <= '0;
              has <= 1'b0;
              if (tcnt == 4'd0) begin
                ch <= acc[CHW-1:0];
                adr_a <= acc[ADR_W-1:0];
              end
              if (tcnt == 4'd1) adr_a <= acc[ADR_W-1:0];
              if (tcnt == 4'd2) adr_e <= acc[ADR_W-1:0];
              if (ch_bad && !bad) begin
                bad <= 1'b1;
                err <= 1'b1;
              end
            end
            if (is_cr) begin
              dat <= pc_data;
              st <= EXEC;
            end
          end else if (nib[4]) begin
            acc <= {acc[27:0], nib[3:0]};
            has <= 1'b1;
          end else if (!bad) begin
            bad <= 1'b1;
            err <= 1'b1;
          end
        end
        EXEC: if (!lf_pend) begin
          if (bad || !ok) begin
            err <= !bad;
            st <= ERR_FLUSH;
          end else if (cmd == 8'h72) begin
            last <= 1'b0;
            st <= RD_REQ;
          end else if (cmd == 8'h67) begin
            start_adr <= adr_a;
            cpu_start <= 1'b1;
            st <= IDLE;
          end else if (cmd == 8'h71) begin
            quit_cmd <= 1'b1;
            st <= IDLE;
          end else if (cmd == 8'h70) begin
            last <= 1'b1;
            hcnt <= '0;
            st <= SEND_HEX;
          end else st <= IDLE;
        end
        RD_REQ: st <= RD_WAIT;
        // last is decided before the increment so a dump ending at the top address never wraps
        RD_WAIT: begin
          dat <= mem_rdata;
          last <= adr_a == adr_e;
          adr_a <= adr_a + 1'b1;
          hcnt <= '0;
          st <= SEND_HEX;
        end
        SEND_HEX: if (slot) begin
          tx_data <= hexc(dat[31:28]);
          tx_valid <= 1'b1;
          dat <= {dat[27:0], 4'h0};
          hcnt <= hcnt == 4'd7 ? 4'd0 : hcnt + 4'd1;
          st <= hcnt == 4'd7 ? SEND_CRLF : SEND_HEX;
        end
        SEND_CRLF: if (slot) begin
          tx_data <= hcnt[0] ? 8'h0a : 8'h0d;
          tx_valid <= 1'b1;
          hcnt <= hcnt + 4'd1;
          st <= !hcnt[0] ? SEND_CRLF : last ? IDLE : RD_REQ;
        end
        ERR_FLUSH: if (slot) begin
          tx_data <= 8'h3f;
          tx_valid <= 1'b1;
          hcnt <= '0;
          last <= 1'b1;
          st <= SEND_CRLF;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_mon_ctrl.sv
// tb_uart_mon_ctrl: scoreboard bench for uart_mon_ctrl with directed command lines.
module tb_uart_mon_ctrl;
  localparam int ADR_W = 10, NCH = 2, CHW = 4;
  logic clk = 0, rst = 1;
  logic [7:0] rx_data = 0, tx_data;
  logic rx_valid = 0, rx_ready, tx_valid, tx_ready = 0;
  logic [CHW-1:0] mem_ch;
  logic [ADR_W-1:0] mem_adr, start_adr;
  logic [31:0] mem_wdata, mem_rdata = 0, pc_data = 0;
  logic mem_wen, mem_ren, cpu_start, quit_cmd, err;

  uart_mon_ctrl #(.ADR_W(ADR_W), .NCH(NCH), .CHW(CHW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .mem_ch(mem_ch), .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
    .mem_ren(mem_ren), .mem_rdata(mem_rdata), .pc_data(pc_data), .cpu_start(cpu_start),
    .quit_cmd(quit_cmd), .start_adr(start_adr), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int err_n = 0, cs_n = 0, q_n = 0, rd_n = 0, tx_n = 0, stall = 0, wc = 0;
  logic pend = 0;
  logic [7:0] pdat = 0;
  logic [7:0] exp_tx[$];
  logic [CHW+ADR_W+31:0] exp_wr[$];
  logic [CHW+ADR_W-1:0] exp_rd[$];
  logic [31:0] model[logic [CHW+ADR_W-1:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic exp_line(input string s);
    for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
    exp_tx.push_back(8'h0d);
    exp_tx.push_back(8'h0a);
  endtask

  task automatic exp_w(input logic [CHW-1:0] c, input logic [ADR_W-1:0] a, input logic [31:0] d);
    exp_wr.push_back({c, a, d});
  endtask

  task automatic exp_r(input logic [CHW-1:0] c, input logic [ADR_W-1:0] a);
    exp_rd.push_back({c, a});
  endtask

  function automatic logic [31:0] rd_model(input logic [CHW+ADR_W-1:0] k);
    return model.exists(k) ? model[k] : 32'h0;
  endfunction

  // memory: data appears the cycle after the mem_ren cycle, garbage otherwise
  initial forever begin
    @(posedge clk);
    mem_rdata <= mem_ren ? rd_model({mem_ch, mem_adr}) : 32'h0BAD0BAD;
  end

  // monitor: drives tx_ready back-pressure and pops the scoreboard on every DUT output
  initial forever begin
    @(negedge clk);
    if (rst) begin
      tx_ready = 0;
      wc = 0;
      pend = 0;
    end else begin
      if (pend) chk("tx_hold", {tx_valid, tx_data}, {1'b1, pdat});
      if (tx_valid) begin
        if (wc >= stall) begin
          tx_ready = 1;
          wc = 0;
        end else begin
          tx_ready = 0;
          wc++;
        end
      end else begin
        tx_ready = 0;
        wc = 0;
      end
      pend = tx_valid && !tx_ready;
      pdat = tx_data;
      if (tx_valid && tx_ready) begin
        tx_n++;
        if (exp_tx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
        end else chk("tx_byte", tx_data, exp_tx.pop_front());
      end
      if (mem_wen) begin
        model[{mem_ch, mem_adr}] = mem_wdata;
        if (exp_wr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL wr_unexpected actual=%0h required=none", {mem_ch, mem_adr, mem_wdata});
        end else chk("mem_write", {mem_ch, mem_adr, mem_wdata}, exp_wr.pop_front());
      end
      if (mem_ren) begin
        rd_n++;
        if (exp_rd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rd_unexpected actual=%0h required=none", {mem_ch, mem_adr});
        end else chk("mem_read", {mem_ch, mem_adr}, exp_rd.pop_front());
      end
      if (err) err_n++;
      if (cpu_start) cs_n++;
      if (quit_cmd) q_n++;
    end
  end

  task automatic sb(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1;
    while (!rx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL rx_timeout actual=%0d required=<2000", n);
    end
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) sb(s[i]);
    sb(8'h0d);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(exp_tx.size() == 0 && exp_wr.size() == 0 && exp_rd.size() == 0 && rx_ready && !tx_valid)
           && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d required=<5000 pending_tx=%0d", n, exp_tx.size());
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk(name, {tx_data, tx_valid, rx_ready, mem_ch, mem_adr, mem_wdata, mem_wen, mem_ren,
               cpu_start, quit_cmd, start_adr, err}, 64'h0);
  endtask

  initial begin
    int e0, r0, t0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset_outputs");
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1 chk("rx_ready_after_reset", rx_ready, 1);
    @(negedge clk);

    exp_w(1, 10'h010, 32'hDEADBEEF);
    exp_w(1, 10'h011, 32'h00000001);
    e0 = err_n;
    send("w 1 0010 DEADBEEF 00000001");
    wait_done();
    chk("w_no_err", err_n - e0, 0);

    stall = 3;
    exp_r(1, 10'h010);
    exp_r(1, 10'h011);
    exp_line("DEADBEEF");
    exp_line("00000001");
    t0 = tx_n;
    send("r 1 0010 0011");
    wait_done();
    chk("r_stall_bytes", tx_n - t0, 20);
    stall = 0;

    model[{4'd0, 10'h3FE}] = 32'h0123ABCD;
    model[{4'd0, 10'h3FF}] = 32'hCAFEF00D;
    exp_r(0, 10'h3FE);
    exp_r(0, 10'h3FF);
    exp_line("0123ABCD");
    exp_line("CAFEF00D");
    r0 = rd_n;
    send("r 0 03FE 03FF");
    wait_done();
    repeat (50) @(negedge clk);
    chk("r_top_no_wrap", rd_n - r0, 2);

    exp_line("?");
    e0 = err_n; r0 = rd_n;
    send("r 2 0000 0001");
    wait_done();
    chk("bad_ch_err", err_n - e0, 1);
    chk("bad_ch_no_rd", rd_n - r0, 0);

    exp_line("?");
    e0 = err_n; r0 = rd_n;
    send("r 0 0005 0004");
    wait_done();
    chk("e_lt_s_err", err_n - e0, 1);
    chk("e_lt_s_no_rd", rd_n - r0, 0);

    send("g 0040");
    wait_done();
    chk("g_start_adr", start_adr, 10'h040);
    chk("g_cpu_start_cycles", cs_n, 1);

    send("q");
    wait_done();
    chk("q_quit_cycles", q_n, 1);
    chk("q_start_adr_held", start_adr, 10'h040);

    pc_data = 32'h00000124;
    exp_line("00000124");
    send("p");
    wait_done();

    t0 = tx_n; e0 = err_n;
    sb(8'h0d);
    wait_done();
    chk("empty_line_tx", tx_n - t0, 0);
    chk("empty_line_err", err_n - e0, 0);

    // truncated address and data, lowercase hex, write pointer wrap
    exp_w(0, 10'h3FF, 32'h23456789);
    exp_w(0, 10'h000, 32'h000000AB);
    send("w 0 13FF 123456789 aB");
    wait_done();

    exp_line("?");
    e0 = err_n;
    send("x 12");
    wait_done();
    chk("unknown_cmd_err", err_n - e0, 1);

    exp_line("?");
    e0 = err_n;
    send("g 00z0");
    wait_done();
    chk("nonhex_err", err_n - e0, 1);

    exp_r(1, 10'h010);
    exp_r(1, 10'h011);
    exp_line("DEADBEEF");
    r0 = rd_n;
    send("r 1 0010 0011");
    for (int n = 0; n < 2000 && rd_n < r0 + 2; n++) @(negedge clk);
    chk("rst_second_read_seen", rd_n - r0, 2);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1 chk_zero("rst_mid_dump_outputs");
    chk("rst_tx_drained", exp_tx.size(), 0);
    exp_tx.delete();
    exp_rd.delete();
    repeat (2) @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1 chk("rx_ready_after_rst2", rx_ready, 1);
    @(negedge clk);
    r0 = rd_n;
    pc_data = 32'hA5F00C31;
    exp_line("A5F00C31");
    send("p");
    wait_done();
    chk("rst_no_more_reads", rd_n - r0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
